// File: rtl/core_pkg.sv
// Shared fetch/decode types: machine widths and the buffered fetch entry.
// Also provides the helper that derives the per-entry misalignment flag.
package core_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
        logic            misaligned;
    } fetch_entry_t;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instr_buffer.sv
// Fetch-to-decode decoupling queue holding {pc, instr, misaligned} entries.
// Optional same-cycle bypass when empty: define INSTR_BUFFER_BYPASS_EN.
module instr_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 64,
    parameter int unsigned ILEN  = 32
) (
    input  logic                       clk,
    input  logic                       reset_sync,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    input  logic [XLEN-1:0]            enq_pc_i,
    input  logic [ILEN-1:0]            enq_instr_i,
    output logic                       enq_ready_o,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [XLEN-1:0]            deq_pc_o,
    output logic [ILEN-1:0]            deq_instr_o,
    output logic                       deq_misaligned_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    import core_pkg::*;

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    fetch_entry_t  enq_entry;
    fetch_entry_t  head;
    logic          empty;
    logic          enq_fire;
    logic          deq_fire;
    logic          do_write;
    logic          do_read;

    // Head selection and handshake qualification.
    always_comb begin
        enq_entry.pc         = enq_pc_i;
        enq_entry.instr      = enq_instr_i;
        enq_entry.misaligned = pc_misaligned(enq_pc_i);

        empty       = (count_q == '0);
        enq_ready_o = (count_q != FULL_COUNT);

        head        = '0;
        deq_valid_o = 1'b0;
        if (!empty) begin
            head        = mem_q[rd_ptr_q];
            deq_valid_o = 1'b1;
        end
`ifdef INSTR_BUFFER_BYPASS_EN
        else if (enq_valid_i && !flush_i) begin
            head        = enq_entry;
            deq_valid_o = 1'b1;
        end
`endif

        deq_pc_o         = head.pc;
        deq_instr_o      = head.instr;
        deq_misaligned_o = head.misaligned;
        count_o          = count_q;

        enq_fire = enq_valid_i && enq_ready_o;
        deq_fire = deq_valid_o && deq_ready_i;
        // A dequeue while empty can only be a bypassed entry: it never touches storage.
        do_read  = deq_fire && !empty;
        do_write = enq_fire && !(empty && deq_fire);
    end

    // Next-state for pointers, occupancy and storage; flush discards everything.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                mem_d[wr_ptr_q] = enq_entry;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (do_write && !do_read) begin
                count_d = count_q + 1'b1;
            end else if (do_read && !do_write) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sync) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    a_no_enq_when_full : assert property (@(posedge clk) disable iff (reset_sync)
        !(do_write && (count_q == FULL_COUNT)));

    a_count_bound : assert property (@(posedge clk) disable iff (reset_sync)
        count_q <= FULL_COUNT);

    a_deq_stable : assert property (@(posedge clk) disable iff (reset_sync)
        (deq_valid_o && !deq_ready_i && !flush_i)
        |=> ($stable(deq_pc_o) && $stable(deq_instr_o) && $stable(deq_misaligned_o)
             && deq_valid_o));

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer against a queue-based reference model.
// Outputs are checked mid-cycle, after inputs settle and before the next edge.
module tb_instr_buffer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 64;
    localparam int unsigned ILEN  = 32;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } ref_entry_t;

    logic                  clk = 1'b0;
    logic                  reset_sync = 1'b1;
    logic                  flush_i = 1'b0;
    logic                  enq_valid_i = 1'b0;
    logic [XLEN-1:0]       enq_pc_i = '0;
    logic [ILEN-1:0]       enq_instr_i = '0;
    logic                  enq_ready_o;
    logic                  deq_valid_o;
    logic                  deq_ready_i = 1'b0;
    logic [XLEN-1:0]       deq_pc_o;
    logic [ILEN-1:0]       deq_instr_o;
    logic                  deq_misaligned_o;
    logic [$clog2(DEPTH):0] count_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    ref_entry_t    model_q[$];
    logic [XLEN-1:0] popped_pcs[$];

    instr_buffer #(.DEPTH(DEPTH), .XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk              (clk),
        .reset_sync       (reset_sync),
        .flush_i          (flush_i),
        .enq_valid_i      (enq_valid_i),
        .enq_pc_i         (enq_pc_i),
        .enq_instr_i      (enq_instr_i),
        .enq_ready_o      (enq_ready_o),
        .deq_valid_o      (deq_valid_o),
        .deq_ready_i      (deq_ready_i),
        .deq_pc_o         (deq_pc_o),
        .deq_instr_o      (deq_instr_o),
        .deq_misaligned_o (deq_misaligned_o),
        .count_o          (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, clock, update the model.
    task automatic step(input logic rst, input logic fl, input logic ev,
                        input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins,
                        input logic dr);
        logic       exp_valid;
        logic       exp_ready;
        logic       bypassed;
        ref_entry_t h;
        int unsigned sz;

        @(negedge clk);
        reset_sync  = rst;
        flush_i     = fl;
        enq_valid_i = ev;
        enq_pc_i    = pc;
        enq_instr_i = ins;
        deq_ready_i = dr;
        #1;

        sz        = model_q.size();
        exp_ready = (sz != DEPTH);
        exp_valid = 1'b0;
        bypassed  = 1'b0;
        h.pc      = '0;
        h.instr   = '0;
        if (sz > 0) begin
            exp_valid = 1'b1;
            h         = model_q[0];
        end
`ifdef INSTR_BUFFER_BYPASS_EN
        else if (ev && !fl) begin
            exp_valid = 1'b1;
            h.pc      = pc;
            h.instr   = ins;
            bypassed  = 1'b1;
        end
`endif

        chk("enq_ready", 64'(enq_ready_o), 64'(exp_ready));
        chk("deq_valid", 64'(deq_valid_o), 64'(exp_valid));
        chk("count", 64'(count_o), 64'(sz));
        chk("deq_pc", 64'(deq_pc_o), 64'(h.pc));
        chk("deq_instr", 64'(deq_instr_o), 64'(h.instr));
        chk("deq_misaligned", 64'(deq_misaligned_o), 64'(h.pc[1:0] != 2'b00));

        @(posedge clk);
        if (rst || fl) begin
            if (!rst && exp_valid && dr) popped_pcs.push_back(h.pc);
            model_q.delete();
        end else begin
            if (exp_valid && dr) begin
                popped_pcs.push_back(h.pc);
                if (!bypassed) void'(model_q.pop_front());
            end
            if (ev && sz < DEPTH && !(bypassed && dr)) begin
                ref_entry_t e;
                e.pc    = pc;
                e.instr = ins;
                model_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input logic dr);
        step(1'b0, 1'b0, 1'b0, '0, '0, dr);
    endtask

    task automatic enq(input logic [XLEN-1:0] pc, input logic dr);
        step(1'b0, 1'b0, 1'b1, pc, ILEN'(32'h0013_0000 ^ pc[31:0]), dr);
    endtask

    initial begin
        bit seen;

        // Reset and idle.
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        repeat (5) idle(1'b0);

        // Single entry round trip.
        step(1'b0, 1'b0, 1'b1, 64'h1000, 32'h0050_0093, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Fill to capacity, refuse a fifth, then drain in order.
        popped_pcs.delete();
        enq(64'h0, 1'b0);
        enq(64'h4, 1'b0);
        enq(64'h8, 1'b0);
        enq(64'hC, 1'b0);
        enq(64'h10, 1'b0);
        enq(64'h14, 1'b1);
        repeat (5) idle(1'b1);
        chk("drain_len", 64'(popped_pcs.size()), 64'd4);
        for (int i = 0; i < 4 && i < popped_pcs.size(); i++)
            chk("drain_order", popped_pcs[i], 64'(4 * i));

        // Streaming at occupancy 2 across pointer wrap.
        popped_pcs.delete();
        enq(64'h100, 1'b0);
        enq(64'h104, 1'b0);
        for (int i = 0; i < 10; i++) enq(64'h108 + 64'(4 * i), 1'b1);
        chk("stream_count", 64'(count_o), 64'd2);
        repeat (3) idle(1'b1);
        for (int i = 0; i < 12 && i < popped_pcs.size(); i++)
            chk("stream_order", popped_pcs[i], 64'h100 + 64'(4 * i));

        // Flush with a concurrent enqueue drops everything.
        popped_pcs.delete();
        enq(64'h300, 1'b0);
        enq(64'h304, 1'b0);
        enq(64'h308, 1'b0);
        step(1'b0, 1'b1, 1'b1, 64'h2000, 32'hDEAD_BEEF, 1'b0);
        repeat (3) idle(1'b1);
        seen = 1'b0;
        foreach (popped_pcs[i]) if (popped_pcs[i] == 64'h2000) seen = 1'b1;
        chk("flush_no_2000", 64'(seen), 64'd0);

        // Misalignment flag.
        enq(64'h1002, 1'b0);
        enq(64'h1004, 1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            logic [XLEN-1:0] rpc;
            rpc = {32'($urandom), 32'($urandom)};
            step($urandom_range(0, 59) == 0, $urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) != 0, rpc, 32'($urandom),
                 $urandom_range(0, 2) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instr_buffer.md
Name: instr_buffer

Overview:
- Decoupling queue between fetch and decode.
- Captures each {pc, instruction} pair returned by fetch and presents it to decode over a valid/ready handshake.
- Absorbs decode stalls without dropping instruction-memory responses.
- Flushed on control-flow redirect so wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, >= 2.
- XLEN, 64, program-counter width.
- ILEN, 32, instruction width.

Ports:
- clk  input  1  core clock
- reset_sync  input  1  synchronous active-high reset
- flush_i  input  1  redirect from execute; discard all entries
- enq_valid_i  input  1  fetch has an instruction this cycle
- enq_pc_i  input  XLEN  pc of the enqueued instruction
- enq_instr_i  input  ILEN  instruction word from fetch
- enq_ready_o  output  1  buffer can accept an entry
- deq_valid_o  output  1  head entry valid for decode
- deq_ready_i  input  1  decode accepts head entry
- deq_pc_o  output  XLEN  pc of head entry
- deq_instr_o  output  ILEN  instruction of head entry
- deq_misaligned_o  output  1  head pc[1:0] != 0
- count_o  output  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Interface: one clock (clk); reset_sync is synchronous, active-high, sampled on posedge clk only.
- Reset:
  - rd_ptr, wr_ptr and count are cleared to 0.
  - After the reset edge: deq_valid_o=0, enq_ready_o=1, count_o=0, deq_pc_o=0, deq_instr_o=0, deq_misaligned_o=0.
  - Entry storage is not reset.
  - Reset asserted mid-operation discards all contents at the next edge, same as flush.
- Handshakes:
  - Enqueue fires when enq_valid_i && enq_ready_o.
  - Dequeue fires when deq_valid_o && deq_ready_i.
- Ready/valid generation:
  - enq_ready_o = (count != DEPTH); it depends only on state, never on deq_ready_i.
  - When full, an enqueue is refused even if a dequeue occurs in the same cycle.
  - deq_valid_o = (count != 0).
- Head outputs:
  - deq_pc_o, deq_instr_o and deq_misaligned_o are driven from the head entry when valid, and are all-zero when empty.
- Latency: an entry enqueued at edge N is visible at deq_* in cycle N+1. There is no combinational path from enq_* to deq_*.
- Pointers:
  - Width $clog2(DEPTH); they wrap naturally from DEPTH-1 to 0.
  - wr_ptr advances on enqueue; rd_ptr advances on dequeue.
- count update:
  - +1 on enqueue only, -1 on dequeue only.
  - Unchanged on simultaneous enqueue and dequeue. This is legal at any occupancy 1..DEPTH-1; at 0 only an enqueue can fire.
- misaligned flag: computed at enqueue as (enq_pc_i[1:0] != 0) and stored with the entry.
- Flush:
  - flush_i set at edge N clears pointers and count at that edge. Any enqueue in that cycle is dropped.
  - A dequeue handshake in the flush cycle is still considered consumed; decode is responsible for squashing it.
  - Priority: reset_sync > flush_i > enqueue/dequeue.
- Assertions (simulation):
  - No enqueue when full.
  - count never exceeds DEPTH.
  - deq_* outputs stable while deq_valid_o && !deq_ready_i.

Optional Feature:
- Macro: INSTR_BUFFER_BYPASS_EN.
- When defined:
  - If count==0 and enq_valid_i and !flush_i, deq_valid_o=1 and deq_* are driven combinationally from enq_*.
  - If deq_ready_i is also high, the entry is consumed without being written (count stays 0).
  - If deq_ready_i is low, the entry is written normally.
- When undefined: minimum enqueue-to-dequeue latency is 1 cycle, as specified above.

Decomposition:
- core_pkg holds:
  - XLEN and ILEN constants.
  - typedef fetch_entry_t = packed struct {pc[XLEN], instr[ILEN], misaligned}.
- The buffer stores an array of fetch_entry_t.
- No sub-module: pointer, count and storage logic stay inline.

Test Plan:
- Reset, then idle: deq_valid_o=0, enq_ready_o=1, count_o=0, deq_instr_o=0 for 5 cycles.
- Enqueue pc=0x1000 instr=0x00500093 with deq_ready_i=1: appears at deq_* the next cycle, count returns to 0 after the dequeue; with the bypass macro it appears the same cycle.
- Hold deq_ready_i=0, enqueue pc 0x0,0x4,0x8,0xC: count_o=4, enq_ready_o=0; a fifth enq is refused. Release: dequeued in order 0x0..0xC, then deq_valid_o=0.
- Continuous enq+deq for 10 cycles from count=2: count_o stays 2, pointers wrap past DEPTH-1, pcs emerge in order.
- With 3 entries, assert flush_i together with enq pc=0x2000: next cycle count_o=0, deq_valid_o=0, and pc 0x2000 is never dequeued.
- Enqueue pc=0x1002: deq_misaligned_o=1 with that entry; pc=0x1004 gives 0.
